// File: rtl/argon_operand_sequencer.sv
// Register-file control sequencer: reads two operands over the shared bus, hands
// them to execute, and writes the returned result back to the destination register.
module argon_operand_sequencer #(
  parameter int unsigned RES_TIMEOUT = 255
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_cmdValid,
  output logic        o_cmdReady,
  input  logic [3:0]  i_cmdA,
  input  logic [3:0]  i_cmdB,
  input  logic [3:0]  i_cmdC,
  input  logic        i_cmdWrite,
  output logic        o_selectLatch,
  output logic        o_outputA,
  output logic        o_outputB,
  output logic        o_latchC,
  output logic [15:0] o_busData,
  input  logic [15:0] i_busData,
  output logic        o_opValid,
  input  logic        i_opReady,
  output logic [15:0] o_opA,
  output logic [15:0] o_opB,
  input  logic        i_resValid,
  input  logic [15:0] i_resData,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout
);

  localparam int unsigned CW = ($clog2(RES_TIMEOUT + 1) > 8) ? $clog2(RES_TIMEOUT + 1) : 8;
  // Expiry is tested on the last permitted WAIT cycle so a result landing there still wins.
  localparam logic [CW-1:0] CNT_LAST = (RES_TIMEOUT == 0) ? '0 : CW'(RES_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEL, S_RDA, S_RDB, S_CAPB, S_ISSUE, S_WAIT, S_WB, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     a_q, a_d, b_q, b_d, c_q, c_d;
  logic           wr_q, wr_d;
  logic [15:0]    opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           tmo_q, tmo_d;
  logic           wait_expired;

  assign wait_expired = (RES_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      wr_q    <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      wr_q    <= wr_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    wr_d    = wr_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (i_cmdValid) begin
          a_d     = i_cmdA;
          b_d     = i_cmdB;
          c_d     = i_cmdC;
          wr_d    = i_cmdWrite;
          state_d = S_SEL;
        end
      end
      S_SEL:  state_d = S_RDA;
      S_RDA:  state_d = S_RDB;
      // The register file registers its bus output, so A appears one cycle after its strobe.
      S_RDB: begin
        opa_d   = i_busData;
        state_d = S_CAPB;
      end
      S_CAPB: begin
        opb_d   = i_busData;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (i_opReady) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        if (i_resValid) begin
          res_d   = i_resData;
          state_d = wr_q ? S_WB : S_DONE;
        end else if (wait_expired) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WB:   state_d = S_DONE;
      S_DONE: begin
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_cmdReady    = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_selectLatch = (state_q == S_SEL);
  assign o_outputA     = (state_q == S_RDA);
  assign o_outputB     = (state_q == S_RDB);
  assign o_latchC      = (state_q == S_WB);
  assign o_opValid     = (state_q == S_ISSUE);
  assign o_done        = (state_q == S_DONE);
  assign o_timeout     = (state_q == S_DONE) && tmo_q;
  assign o_opA         = opa_q;
  assign o_opB         = opb_q;
  assign o_busData     = (state_q == S_SEL) ? {4'h0, c_q, b_q, a_q} :
                         (state_q == S_WB)  ? res_q : 16'h0000;

endmodule

// File: doc/argon_operand_sequencer.md
# argon_operand_sequencer

Control stage that sits directly upstream of the Argon register file. It accepts one register-operation command (source indices A/B, destination C, write flag) and drives the register file's select/output/latch strobes over the shared 16-bit bus. It captures both operands, hands them to the execute stage through a valid/ready handshake, and writes the returned result back to register C. There is a single command in flight at a time.

## Interface
- RES_TIMEOUT, 255: maximum number of cycles spent waiting for a result; 0 disables the timeout.
- i_Clk  in  1  single clock; all logic on rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_cmdValid  in  1  command present.
- o_cmdReady  out  1  sequencer can accept a command (high only in IDLE).
- i_cmdA / i_cmdB / i_cmdC  in  4 each  source A, source B, destination indices.
- i_cmdWrite  in  1  1 = write result back to C.
- o_selectLatch / o_outputA / o_outputB / o_latchC  out  1 each  register-file control strobes.
- o_busData  out  16  data driven to the register-file bus input.
- i_busData  in  16  register-file bus output (registered inside the register file).
- o_opValid  out  1  operands valid to execute stage.
- i_opReady  in  1  execute stage accepts operands.
- o_opA / o_opB  out  16 each  captured operands, stable from the capture edge until the next command.
- i_resValid  in  1  result valid.
- i_resData  in  16  result word.
- o_busy  out  1  state != IDLE.
- o_done  out  1  one-cycle completion pulse.
- o_timeout  out  1  one-cycle pulse alongside o_done when the result wait expired.

## Operation
- States: IDLE, SEL, RDA, RDB, CAPB, ISSUE, WAIT, WB, DONE.
- IDLE: o_cmdReady=1. When i_cmdValid=1, latch A/B/C/write into internal registers and go to SEL.
- SEL: o_selectLatch=1; o_busData={4'h0, C, B, A} (C in [11:8], B in [7:4], A in [3:0]). Next state: RDA.
- RDA: o_outputA=1. Next state: RDB.
- RDB: o_outputB=1. At the end of the cycle, capture i_busData into o_opA. Next state: CAPB.
- CAPB: capture i_busData into o_opB. Next state: ISSUE.
- ISSUE: o_opValid=1 and held until i_opReady=1; then go to WAIT and clear the wait counter. i_resValid is ignored in ISSUE.
- WAIT: the counter increments each cycle.
  - On i_resValid=1: capture i_resData into the result register; go to WB if write=1, otherwise DONE.
  - If RES_TIMEOUT!=0 and the counter reaches RES_TIMEOUT with no result: go to DONE with the timeout flag set. No writeback occurs.
  - If i_resValid arrives in the same cycle as the expiry, the result wins.
- WB: o_latchC=1; o_busData=result register. C=0 is still issued; the register file discards it. Next state: DONE.
- DONE: o_done=1; o_timeout=timeout flag. Next state: IDLE; the flag clears.
- At most one of the four strobes is high in any cycle. o_busData=0 outside SEL and WB.
- Counter width is 8 bits minimum, sized to hold RES_TIMEOUT. It saturates and never wraps.

## Timing
- Reset values: state IDLE; o_cmdReady=1; all strobes, o_opValid, o_done, o_timeout and o_busy = 0; o_busData, o_opA, o_opB and the result register = 0; counter = 0.
- Reset asserted mid-operation returns to IDLE immediately. No strobe is asserted after reset, and no partial writeback occurs.
- Command accepted at edge 0 gives:
  - SEL in cycle 1, RDA in cycle 2, RDB in cycle 3, CAPB in cycle 4.
  - ISSUE from cycle 5 (o_opA/o_opB valid from cycle 4 and cycle 5 respectively).
- With i_opReady=1 in cycle 5 and i_resValid=1 in cycle 6: WB in cycle 7, DONE in cycle 8, o_cmdReady=1 in cycle 9.
- Minimum command-to-command spacing: 9 cycles (8 if no writeback).
- o_cmdReady is a combinational decode of state, with no dependency on i_cmdValid.

## Test plan
- Reset, then preload r3=0x1234 and r5=0x00FF. Command A=3, B=5, C=7, write=1; execute stage returns 0x1333 one cycle after handshake → o_busData=0x0753 in SEL; o_opA=0x1234, o_opB=0x00FF; o_latchC in cycle 7 with o_busData=0x1333; o_done in cycle 8.
- Same command with i_opReady held low for 4 cycles → o_opValid stays high with operands stable; WB is delayed by exactly 4 cycles.
- write=0 → o_latchC never asserts; o_done one cycle after the result is accepted.
- RES_TIMEOUT=4 with no i_resValid → o_done and o_timeout together after 4 WAIT cycles; no o_latchC. A result arriving exactly on the expiry cycle is written back with o_timeout=0.
- Source A=0 and C=0 → o_opA=0x0000; o_latchC asserts with o_busData=result and the register file is unchanged.
- i_Reset pulsed during WAIT → all outputs at reset values the same cycle; the next command completes normally.
